i2c_line_packer: RTL

//  Upstream feeder for sdram_controller. Collects 32-bit words from I2C_slave
//  (DOUT_H/L3/L2/L pulse-qualified by FIN), packs 4 words into one 128-bit line,
//  and writes each line to SDRAM at an auto-incrementing address over the

---
 rtl/i2c_line_packer_if.sv | 27 ++
 rtl/i2c_line_packer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2c_line_packer_if.sv
// SDRAM line-write handshake between the packer and sdram_controller.
// write_request rises with address/data valid; both stay frozen until write_finished is seen.
interface i2c_line_packer_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              write_request;
  logic [ADDR_W-1:0] write_address;
  logic [127:0]      write_data;
  logic              write_finished;
  logic [1:0]        wr_state;

  modport master (
    output write_request,
    output write_address,
    output write_data,
    output wr_state,
    input  write_finished
  );

  modport slave (
    input  write_request,
    input  write_address,
    input  write_data,
    input  wr_state,
    output write_finished
  );
endinterface

// File: rtl/i2c_line_packer.sv
// Packs 32-bit I2C words into 128-bit lines and writes them to SDRAM at
// auto-incrementing line addresses; double-buffered (fill + pending), with flush.
module i2c_line_packer #(
  parameter int unsigned       ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  input  logic              FIN,
  input  logic [7:0]        DOUT_L,
  input  logic [7:0]        DOUT_L2,
  input  logic [7:0]        DOUT_L3,
  input  logic [7:0]        DOUT_H,
  input  logic              FLUSH,
  i2c_line_packer_if.master wr,
  output logic [ADDR_W-1:0] LINE_COUNT,
  output logic              OVERFLOW,
  output logic              BUSY,
  output logic              FLUSH_DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              fin_prev_q,   fin_prev_d;
  logic              flush_prev_q, flush_prev_d;
  logic [1:0]        wcnt_q,       wcnt_d;
  logic [127:0]      fill_q,       fill_d;
  logic              fill_full_q,  fill_full_d;
  logic [127:0]      pend_q,       pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic [1:0]        state_q,      state_d;
  logic              req_q,        req_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [127:0]      data_q,       data_d;
  logic [ADDR_W-1:0] count_q,      count_d;
  logic              ovf_q,        ovf_d;
  logic              fdone_q,      fdone_d;

  logic        fin_edge;
  logic        flush_edge;
  logic [31:0] word;

  assign fin_edge   = FIN & ~fin_prev_q;
  assign flush_edge = FLUSH & ~flush_prev_q;
  assign word       = {DOUT_H, DOUT_L3, DOUT_L2, DOUT_L};

  always_comb begin
    fin_prev_d   = FIN;
    flush_prev_d = FLUSH;
    wcnt_d       = wcnt_q;
    fill_d       = fill_q;
    fill_full_d  = fill_full_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    flush_pend_d = flush_pend_q;
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    fdone_d      = 1'b0;

    // A full fill hands over to pending as soon as pending is free; fill restarts zeroed.
    if (fill_full_q && !pend_valid_q) begin
      pend_d       = fill_q;
      pend_valid_d = 1'b1;
      fill_d       = '0;
      fill_full_d  = 1'b0;
    end

    if (fin_edge) begin
      if (fill_full_q) begin
        ovf_d = 1'b1;
      end else begin
        fill_d[{wcnt_q, 5'b0} +: 32] = word;
        if (wcnt_q == 2'd3) begin
          fill_full_d = 1'b1;
          wcnt_d      = 2'd0;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
    end

    if (flush_pend_q && !fin_edge && wcnt_q == 2'd0 && !fill_full_q &&
        !pend_valid_q && state_q == S_IDLE) begin
      fdone_d      = 1'b1;
      flush_pend_d = 1'b0;
    end

    // Flush pads after this cycle's word lands; unwritten slots are already zero.
    if (flush_edge) begin
      flush_pend_d = 1'b1;
      if (wcnt_d != 2'd0 && !fill_full_d) begin
        fill_full_d = 1'b1;
        wcnt_d      = 2'd0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          data_d  = pend_q;
        end
      end
      S_REQ: begin
        if (wr.write_finished) begin
          state_d = S_DONE;
          req_d   = 1'b0;
        end
      end
      S_DONE: begin
        pend_valid_d = 1'b0;
        count_d      = count_q + ADDR_W'(1);
        addr_d       = (addr_q == ADDR_LIMIT) ? BASE_ADDR : addr_q + ADDR_W'(1);
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      fin_prev_q   <= 1'b0;
      flush_prev_q <= 1'b0;
      wcnt_q       <= 2'd0;
      fill_q       <= '0;
      fill_full_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      fdone_q      <= 1'b0;
    end else begin
      fin_prev_q   <= fin_prev_d;
      flush_prev_q <= flush_prev_d;
      wcnt_q       <= wcnt_d;
      fill_q       <= fill_d;
      fill_full_q  <= fill_full_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      fdone_q      <= fdone_d;
    end
  end

  assign wr.write_request = req_q;
  assign wr.write_address = addr_q;
  assign wr.write_data    = data_q;
  assign wr.wr_state      = state_q;

  assign LINE_COUNT = count_q;
  assign OVERFLOW   = ovf_q;
  assign FLUSH_DONE = fdone_q;
  assign BUSY       = (wcnt_q != 2'd0) | fill_full_q | pend_valid_q | (state_q != S_IDLE);

endmodule
